// File: rtl/bpred_pkg.sv
// Shared types and widths for the branch-predictor update controller:
// index/target widths, the FSM state encoding and the queued update record.
package bpred_pkg;

  localparam int BPRED_IDX_W = 5;
  localparam int BPRED_TGT_W = 30;

  // IDLE: nothing queued. PEND: updates queued, fetch has the read port.
  // FORCE: an update has waited too long and takes the port this cycle.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_FORCE = 2'd2
  } bpred_state_e;

  // One resolved branch waiting to be written into the predictor table.
  typedef struct packed {
    logic [BPRED_IDX_W-1:0] idx;
    logic                   taken;
    logic [BPRED_TGT_W-1:0] target;
  } bpred_upd_t;

endpackage

// File: rtl/bpred_upd_fifo.sv
// Synchronous update queue with a single-cycle flush. The head entry is
// presented combinationally (all-zero when empty) so the table port mux in
// the top can drive it without an extra register stage.
module bpred_upd_fifo
  import bpred_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       i_push,
  input  bpred_upd_t i_data,
  input  logic       i_pop,
  input  logic       i_flush,
  output bpred_upd_t o_head,
  output logic       o_empty,
  output logic       o_full,
  output logic       o_last
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  bpred_upd_t       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_last  = (r_count == CNT_W'(1));

  // A push into a full queue is refused even if the head pops this cycle.
  assign w_push = i_push & ~o_full & ~i_flush;
  assign w_pop  = i_pop & ~o_empty & ~i_flush;

  assign o_head = o_empty ? '0 : r_mem[r_rd_ptr];

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so the
  // pointers wrap naturally at their bit width.
  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage, written at the tail on an accepted push.
  // NOTE: the storage array has no reset; validity comes solely from the
  // reset pointers/count, which keeps it mappable to plain RAM.
  always_ff @(posedge Clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/bpred_update_ctrl.sv
// Branch predictor update controller: queues resolved branches and arbitrates
// the predictor's shared read port between fetch lookups and table updates
// (read-modify-write). Fetch has priority until an update has been denied
// STARVE_MAX consecutive cycles, after which one update is forced through.
// Optional build macro BPRED_UPDATE_CTRL_STATS_EN adds stat_writes and
// stat_forced wrapping counters.
module bpred_update_ctrl
  import bpred_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   fetch_req,
  input  logic [BPRED_IDX_W-1:0] fetch_idx,
  output logic                   fetch_grant,
  output logic [BPRED_TGT_W-1:0] pred_target,
  output logic                   pred_taken,
  input  logic                   upd_valid,
  input  logic [BPRED_IDX_W-1:0] upd_idx,
  input  logic                   upd_taken,
  input  logic [BPRED_TGT_W-1:0] upd_target,
  output logic                   upd_ready,
  input  logic                   flush,
  output logic [BPRED_IDX_W-1:0] tbl_addrr,
  output logic [BPRED_IDX_W-1:0] tbl_addrw,
  output logic                   tbl_we,
  output logic                   tbl_next,
  output logic [BPRED_TGT_W-1:0] tbl_wdata,
  input  logic [BPRED_TGT_W:0]   tbl_rdata,
  output logic                   busy
`ifdef BPRED_UPDATE_CTRL_STATS_EN
  ,
  output logic [15:0]            stat_writes,
  output logic [15:0]            stat_forced
`endif
);

  localparam int                CNT_W      = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  bpred_state_e     r_state;
  logic [CNT_W-1:0] r_starve;
  logic [CNT_W-1:0] w_starve_inc;
  bpred_upd_t       w_in;
  bpred_upd_t       w_head;
  logic             w_empty;
  logic             w_full;
  logic             w_last;
  logic             w_push;
  logic             w_write;

  assign w_in = '{idx: upd_idx, taken: upd_taken, target: upd_target};

  bpred_upd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .Clk     (Clk),
    .Reset   (Reset),
    .i_push  (w_push),
    .i_data  (w_in),
    .i_pop   (w_write),
    .i_flush (flush),
    .o_head  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_last  (w_last)
  );

  assign upd_ready = ~w_full;
  assign busy      = ~w_empty;
  assign w_push    = upd_valid & ~w_full & ~flush;

  // Decide whether the head update owns the table port this cycle.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_write = 1'b0;
    unique case (r_state)
      ST_PEND:  w_write = ~fetch_req;
      ST_FORCE: w_write = 1'b1;
      default:  w_write = 1'b0;
    endcase
    if (flush || w_empty) w_write = 1'b0;
  end

  // Port mux: lookup and update share the read address; write side always
  // shows the head fields.
  assign fetch_grant = fetch_req & ~w_write;
  assign pred_target = fetch_grant ? tbl_rdata[BPRED_TGT_W:1] : '0;
  assign pred_taken  = fetch_grant & tbl_rdata[0];
  assign tbl_addrr   = w_write ? w_head.idx : fetch_idx;
  assign tbl_addrw   = w_head.idx;
  assign tbl_we      = w_write;
  assign tbl_next    = w_head.taken;
  assign tbl_wdata   = w_head.target;

  assign w_starve_inc = (r_starve == STARVE_LIM) ? r_starve : r_starve + CNT_W'(1);

  // Arbitration FSM and starve counter.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state  <= ST_IDLE;
      r_starve <= '0;
    end else if (flush) begin
      r_state  <= ST_IDLE;
      r_starve <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          r_starve <= '0;
          if (w_push) r_state <= ST_PEND;
        end
        ST_PEND: begin
          if (fetch_req) begin
            r_starve <= w_starve_inc;
            if (w_starve_inc == STARVE_LIM) r_state <= ST_FORCE;
          end else begin
            r_starve <= '0;
            if (w_last && !w_push) r_state <= ST_IDLE;
          end
        end
        ST_FORCE: begin
          r_starve <= '0;
          r_state  <= (w_last && !w_push) ? ST_IDLE : ST_PEND;
        end
        default: begin
          r_starve <= '0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef BPRED_UPDATE_CTRL_STATS_EN
  logic [15:0] r_stat_writes;
  logic [15:0] r_stat_forced;

  // Free-running activity counters; flush leaves them untouched.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_stat_writes <= '0;
      r_stat_forced <= '0;
    end else begin
      if (w_write)             r_stat_writes <= r_stat_writes + 16'd1;
      if (r_state == ST_FORCE) r_stat_forced <= r_stat_forced + 16'd1;
    end
  end

  assign stat_writes = r_stat_writes;
  assign stat_forced = r_stat_forced;
`endif

endmodule

// File: tb/tb_bpred_update_ctrl.sv
// Self-checking bench for bpred_update_ctrl: directed scenarios for the
// documented examples followed by randomized traffic compared against a
// queue-based reference model of the arbitration rules.
module tb_bpred_update_ctrl;
  import bpred_pkg::*;

  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 3;

  logic                   Clk = 1'b0;
  logic                   Reset;
  logic                   fetch_req;
  logic [BPRED_IDX_W-1:0] fetch_idx;
  logic                   fetch_grant;
  logic [BPRED_TGT_W-1:0] pred_target;
  logic                   pred_taken;
  logic                   upd_valid;
  logic [BPRED_IDX_W-1:0] upd_idx;
  logic                   upd_taken;
  logic [BPRED_TGT_W-1:0] upd_target;
  logic                   upd_ready;
  logic                   flush;
  logic [BPRED_IDX_W-1:0] tbl_addrr;
  logic [BPRED_IDX_W-1:0] tbl_addrw;
  logic                   tbl_we;
  logic                   tbl_next;
  logic [BPRED_TGT_W-1:0] tbl_wdata;
  logic [BPRED_TGT_W:0]   tbl_rdata;
  logic                   busy;
`ifdef BPRED_UPDATE_CTRL_STATS_EN
  logic [15:0]            stat_writes;
  logic [15:0]            stat_forced;
`endif

  always #5 Clk = ~Clk;

  bpred_update_ctrl #(
    .DEPTH      (DEPTH),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .fetch_req   (fetch_req),
    .fetch_idx   (fetch_idx),
    .fetch_grant (fetch_grant),
    .pred_target (pred_target),
    .pred_taken  (pred_taken),
    .upd_valid   (upd_valid),
    .upd_idx     (upd_idx),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target),
    .upd_ready   (upd_ready),
    .flush       (flush),
    .tbl_addrr   (tbl_addrr),
    .tbl_addrw   (tbl_addrw),
    .tbl_we      (tbl_we),
    .tbl_next    (tbl_next),
    .tbl_wdata   (tbl_wdata),
    .tbl_rdata   (tbl_rdata),
    .busy        (busy)
`ifdef BPRED_UPDATE_CTRL_STATS_EN
    ,
    .stat_writes (stat_writes),
    .stat_forced (stat_forced)
`endif
  );

  // Reference model: pending updates in arrival order, how many cycles in a
  // row fetch has beaten the oldest update, and whether an update is owed
  // the port.
  bpred_upd_t m_q[$];
  int         m_starve;
  bit         m_force;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_starve = 0;
    m_force  = 1'b0;
  endtask

  function automatic bit model_write();
    return !flush && (m_q.size() > 0) && (m_force || !fetch_req);
  endfunction

  // Compare every output against the model for the current inputs.
  task automatic check_outputs(input string ctx);
    bpred_upd_t             h;
    bit                     wr;
    bit                     gr;
    logic [BPRED_IDX_W-1:0] exp_addrr;
    h         = (m_q.size() > 0) ? m_q[0] : '0;
    wr        = model_write();
    gr        = fetch_req && !wr;
    exp_addrr = wr ? h.idx : fetch_idx;
    check({ctx, ".grant"},   64'(fetch_grant), 64'(gr));
    check({ctx, ".ptarget"}, 64'(pred_target), gr ? 64'(tbl_rdata[BPRED_TGT_W:1]) : 64'd0);
    check({ctx, ".ptaken"},  64'(pred_taken),  gr ? 64'(tbl_rdata[0]) : 64'd0);
    check({ctx, ".we"},      64'(tbl_we),      64'(wr));
    check({ctx, ".addrr"},   64'(tbl_addrr),   64'(exp_addrr));
    check({ctx, ".addrw"},   64'(tbl_addrw),   64'(h.idx));
    check({ctx, ".next"},    64'(tbl_next),    64'(h.taken));
    check({ctx, ".wdata"},   64'(tbl_wdata),   64'(h.target));
    check({ctx, ".ready"},   64'(upd_ready),   64'(m_q.size() < DEPTH));
    check({ctx, ".busy"},    64'(busy),        64'(m_q.size() > 0));
  endtask

  // Advance the model by one clock edge using the pre-edge inputs.
  task automatic model_edge();
    bit         wr;
    bit         rdy;
    bpred_upd_t e;
    wr  = model_write();
    rdy = m_q.size() < DEPTH;
    if (flush) begin
      model_reset();
    end else begin
      if (wr) begin
        m_q.delete(0);
        m_starve = 0;
        m_force  = 1'b0;
      end else if (m_q.size() > 0 && fetch_req) begin
        m_starve++;
        if (m_starve >= STARVE_MAX) m_force = 1'b1;
      end
      if (upd_valid && rdy) begin
        e.idx    = upd_idx;
        e.taken  = upd_taken;
        e.target = upd_target;
        m_q.push_back(e);
      end
    end
  endtask

  // One clock cycle: check outputs, update model, take the edge.
  task automatic step(input string ctx);
    #1;
    check_outputs(ctx);
    model_edge();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    fetch_req  = 1'b0;
    fetch_idx  = '0;
    upd_valid  = 1'b0;
    upd_idx    = '0;
    upd_taken  = 1'b0;
    upd_target = '0;
    flush      = 1'b0;
  endtask

  task automatic push_in(input logic [4:0] idx, input logic tk, input logic [29:0] tgt);
    upd_valid  = 1'b1;
    upd_idx    = idx;
    upd_taken  = tk;
    upd_target = tgt;
  endtask

  initial begin
    idle_inputs();
    tbl_rdata = '0;
    model_reset();

    // Reset state with a live lookup request.
    Reset     = 1'b0;
    fetch_req = 1'b1;
    fetch_idx = 5'd7;
    tbl_rdata = {30'h1234, 1'b1};
    #3;
    check("rst.grant",   64'(fetch_grant), 64'd1);
    check("rst.ptarget", 64'(pred_target), 64'h1234);
    check("rst.ptaken",  64'(pred_taken),  64'd1);
    check("rst.we",      64'(tbl_we),      64'd0);
    check("rst.addrr",   64'(tbl_addrr),   64'd7);
    check("rst.ready",   64'(upd_ready),   64'd1);
    check("rst.busy",    64'(busy),        64'd0);
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    #1;

    // Single update with fetch idle: written the cycle after enqueue.
    idle_inputs();
    push_in(5'd3, 1'b1, 30'h40);
    step("enq1");
    idle_inputs();
    #1;
    check("rmw.we",    64'(tbl_we),    64'd1);
    check("rmw.addrr", 64'(tbl_addrr), 64'd3);
    check("rmw.addrw", 64'(tbl_addrw), 64'd3);
    check("rmw.next",  64'(tbl_next),  64'd1);
    check("rmw.wdata", 64'(tbl_wdata), 64'h40);
    step("rmw");
    #1;
    check("rmw.busy_after", 64'(busy), 64'd0);

    // Starvation: fetch wins STARVE_MAX cycles, then one forced write.
    fetch_req = 1'b1;
    push_in(5'd9, 1'b0, 30'h2abc);
    step("starve_enq");
    upd_valid = 1'b0;
    for (int i = 0; i < STARVE_MAX; i++) begin
      #1;
      check("starve.grant", 64'(fetch_grant), 64'd1);
      check("starve.we",    64'(tbl_we),      64'd0);
      step("starve");
    end
    #1;
    check("force.grant", 64'(fetch_grant), 64'd0);
    check("force.we",    64'(tbl_we),      64'd1);
    check("force.addrr", 64'(tbl_addrr),   64'd9);
    step("force");

    // Back-pressure: five pushes into a 4-deep queue with fetch held.
    fetch_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_in(5'(i + 16), i[0], 30'(32'h100 + i));
      step("fill");
    end
    push_in(5'd21, 1'b1, 30'h105);
    #1;
    check("full.ready", 64'(upd_ready), 64'd0);
    check("full.we",    64'(tbl_we),    64'd1);
    step("full_pop");
    #1;
    check("full.ready_after_pop", 64'(upd_ready), 64'd1);
    step("fifth");
    idle_inputs();
    for (int i = 0; i < 6; i++) step("drain");
    check("drain.busy", 64'(busy), 64'd0);

    // Flush with three entries queued; enqueue in the flush cycle is dropped.
    fetch_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_in(5'(i + 1), 1'b1, 30'(32'h200 + i));
      step("pre_flush");
    end
    flush = 1'b1;
    push_in(5'd30, 1'b0, 30'h3ff);
    #1;
    check("flush.we", 64'(tbl_we), 64'd0);
    step("flush");
    idle_inputs();
    fetch_req = 1'b1;
    #1;
    check("flush.busy",  64'(busy),        64'd0);
    check("flush.ready", 64'(upd_ready),   64'd1);
    check("flush.we2",   64'(tbl_we),      64'd0);
    check("flush.grant", 64'(fetch_grant), 64'd1);
    step("post_flush");

    // Reset in the middle of a forced write.
    push_in(5'd12, 1'b1, 30'h777);
    step("rf_enq");
    upd_valid = 1'b0;
    for (int i = 0; i < STARVE_MAX; i++) step("rf_starve");
    #1;
    check("rf.we_before", 64'(tbl_we), 64'd1);
    Reset = 1'b0;
    #1;
    check("rf.we",    64'(tbl_we),      64'd0);
    check("rf.busy",  64'(busy),        64'd0);
    check("rf.ready", 64'(upd_ready),   64'd1);
    check("rf.grant", 64'(fetch_grant), 64'd1);
    model_reset();
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    step("rf_idle");

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      fetch_req  = ($urandom_range(0, 99) < 70);
      fetch_idx  = 5'($urandom());
      upd_valid  = ($urandom_range(0, 99) < 50);
      upd_idx    = 5'($urandom());
      upd_taken  = 1'($urandom());
      upd_target = 30'($urandom());
      flush      = ($urandom_range(0, 99) < 3);
      tbl_rdata  = 31'($urandom());
      step("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bpred_update_ctrl.md
BPRED_UPDATE_CTRL -- requirements
Module: bpred_update_ctrl

Interface
REQ-001 Parameter DEPTH, default 4: update-queue entries; power of two, 2..16.
REQ-002 Parameter STARVE_MAX, default 3: consecutive denied update cycles before an update is forced onto the table port.
REQ-003 Clk  input  1  clock; all state updates on rising edge.
REQ-004 Reset  input  1  reset, asynchronous, active-low.
REQ-005 fetch_req  input  1  fetch stage requests a prediction lookup this cycle.
REQ-006 fetch_idx  input  5  lookup index.
REQ-007 fetch_grant  output  1  lookup serviced this cycle; pred_* valid.
REQ-008 pred_target  output  30  predicted target word address (tbl_rdata[30:1]).
REQ-009 pred_taken  output  1  predicted direction (tbl_rdata[0]).
REQ-010 upd_valid  input  1  execute stage presents a resolved branch.
REQ-011 upd_idx  input  5  index of the resolved branch.
REQ-012 upd_taken  input  1  actual outcome.
REQ-013 upd_target  input  30  actual target word address.
REQ-014 upd_ready  output  1  queue can accept; transfer when upd_valid and upd_ready.
REQ-015 flush  input  1  synchronous discard of all queued updates.
REQ-016 tbl_addrr  output  5  predictor read address.
REQ-017 tbl_addrw  output  5  predictor write address.
REQ-018 tbl_we  output  1  predictor write enable.
REQ-019 tbl_next  output  1  outcome fed to predictor 2-bit counter logic.
REQ-020 tbl_wdata  output  30  target written to predictor.
REQ-021 tbl_rdata  input  31  predictor read data {target[29:0], taken}.
REQ-022 busy  output  1  queue non-empty.

Function
REQ-023 The block SHALL own a FIFO of DEPTH entries of {idx, taken, target}; upd_ready = not full; busy = not empty.
REQ-024 The predictor read port is shared: a queue write performs read-modify-write in one cycle with tbl_addrr = tbl_addrw = head idx, tbl_we = 1, tbl_next = head taken, tbl_wdata = head target; head pops at that edge.
REQ-025 In cycles without a queue write: tbl_addrr = fetch_idx, tbl_we = 0; tbl_addrw, tbl_next, tbl_wdata = head fields (0 when empty).
REQ-026 FSM states: IDLE (queue empty), PEND (queue non-empty, fetch priority), FORCE (update owns port).
REQ-027 IDLE: fetch_grant = fetch_req; go PEND when an entry is enqueued.
REQ-028 PEND: if fetch_req, fetch_grant = 1, no write, starve counter +1; else write head and clear counter; go FORCE when counter reaches STARVE_MAX; go IDLE when last entry pops with no enqueue.
REQ-029 FORCE: fetch_grant = 0, write head, clear counter; next state PEND if entries remain, else IDLE.
REQ-030 fetch_grant, pred_target, pred_taken are combinational from fetch_req and tbl_rdata (zero-latency lookup); pred_* = 0 when fetch_grant = 0.
REQ-031 Enqueue to empty queue at edge N: earliest table write in cycle N+1; no same-cycle bypass.
REQ-032 Simultaneous enqueue and pop when full: upd_ready = 0 still; no enqueue that cycle.
REQ-033 Pointers wrap modulo DEPTH; counter saturates at STARVE_MAX.
REQ-034 flush: in the flush cycle tbl_we = 0 and any enqueue is dropped; the queue empties, the starve counter clears and the FSM returns to IDLE at the next edge.

Reset
REQ-035 Reset low SHALL asynchronously empty the queue, clear the starve counter, set the FSM to IDLE; tbl_we = 0, upd_ready = 1, busy = 0, fetch_grant follows fetch_req; a reset mid-write leaves the table entry to the predictor's own reset.

Configuration
REQ-036 With macro BPRED_UPDATE_CTRL_STATS_EN defined: outputs stat_writes[15:0] (table writes) and stat_forced[15:0] (FORCE cycles), wrapping counters cleared by Reset, not by flush; without it, those ports and counters do not exist.

Structure
REQ-037 Shared package bpred_pkg: BPRED_IDX_W = 5, BPRED_TGT_W = 30, the FSM state enum, and the queue entry struct.
REQ-038 One sub-module bpred_upd_fifo (DEPTH-parameterised synchronous FIFO with flush); the FSM and port mux live in the top.

Verification
REQ-039 Reset, fetch_req = 1, fetch_idx = 7, tbl_rdata = {30'h1234, 1} -> fetch_grant = 1, pred_target = 30'h1234, pred_taken = 1, tbl_we = 0.
REQ-040 fetch_req = 0, push idx = 3, taken = 1, target = 30'h40 -> next cycle tbl_we = 1, addrr = addrw = 3, tbl_next = 1, tbl_wdata = 30'h40; busy = 0 after.
REQ-041 Continuous fetch_req, one queued update, STARVE_MAX = 3 -> grants in 3 cycles, then 1 FORCE cycle with fetch_grant = 0, tbl_we = 1.
REQ-042 Push 5 updates with DEPTH = 4 and fetch_req held -> upd_ready = 0 after 4th; 5th accepted only after first pop.
REQ-043 Queue holding 3 entries, flush = 1 for one cycle -> no tbl_we, busy = 0, upd_ready = 1 at next cycle.
REQ-044 Reset asserted during a FORCE cycle -> tbl_we drops immediately, busy = 0, FSM IDLE.
